riscv_data_port: RTL

- Processor-side initiator for the word-wide synchronous data memory port (dAddress/MemWrite/dWriteData/dReadData).
- Accepts RISC-V load/store requests of byte, halfword or word size over a valid/ready handshake, then drives the word-only memory interface.
  - Loads are aligned and sign- or zero-extended.
  - Sub-word stores use read-modify-write.
- Results return on a one-cycle response pulse. Sits between the pipeline MEM stage and the data memory.

---
 rtl/riscv_data_port.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/riscv_data_port.sv
// Load/store initiator for a word-wide synchronous data memory with a one-cycle read latency.
// Define RISCV_DATA_PORT_SUBWORD_STORE_EN to build SB/SH read-modify-write; otherwise they are rejected.
module riscv_data_port #(
  parameter logic [31:0] DATA_START_ADDRESS = 32'h00800000,
  parameter int unsigned DATA_BRAMS         = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam int unsigned AW = 11 + DATA_BRAMS;

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, RESP} state_e;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic        req_err;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_rdata;
  logic [31:0] merged;

  always_comb begin
    req_err = 1'b0;
    if (req_write) begin
`ifdef RISCV_DATA_PORT_SUBWORD_STORE_EN
      if (req_funct3 > 3'd2) req_err = 1'b1;
`else
      if (req_funct3 != 3'd2) req_err = 1'b1;
`endif
    end else if (req_funct3 inside {3'd3, 3'd6, 3'd7}) begin
      req_err = 1'b1;
    end
    if (req_funct3[1:0] == 2'd1 && req_addr[0]) req_err = 1'b1;
    if (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0) req_err = 1'b1;
    if (req_addr[31:AW] != DATA_START_ADDRESS[31:AW]) req_err = 1'b1;
  end

  // Little-endian lane pick; funct3[2] selects zero extension.
  always_comb begin
    byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
    half_sel = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'd0:    ext_rdata = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    ext_rdata = {{16{half_sel[15]}}, half_sel};
      3'd4:    ext_rdata = {24'd0, byte_sel};
      3'd5:    ext_rdata = {16'd0, half_sel};
      default: ext_rdata = mem_rdata;
    endcase
  end

`ifdef RISCV_DATA_PORT_SUBWORD_STORE_EN
  // mem_wdata_q still holds the right-justified store data while in RD_DATA.
  always_comb begin
    merged = mem_rdata;
    if (funct3_q[0]) merged[{lane_q[1], 4'b0000} +: 16] = mem_wdata_q[15:0];
    else             merged[{lane_q, 3'b000} +: 8]      = mem_wdata_q[7:0];
  end
`else
  assign merged = mem_wdata_q;
`endif

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    funct3_d     = funct3_q;
    lane_d       = lane_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        write_d  = req_write;
        funct3_d = req_funct3;
        lane_d   = req_addr[1:0];
        if (req_err) begin
          state_d      = RESP;
          resp_err_d   = 1'b1;
          resp_rdata_d = 32'd0;
        end else begin
          mem_addr_d  = {req_addr[31:2], 2'b00};
          mem_wdata_d = req_wdata;
          state_d     = (req_write && req_funct3 == 3'd2) ? WR : RD_ADDR;
        end
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        if (write_q) begin
          mem_wdata_d = merged;
          state_d     = WR;
        end else begin
          resp_rdata_d = ext_rdata;
          resp_err_d   = 1'b0;
          state_d      = RESP;
        end
      end
      WR: begin
        resp_rdata_d = 32'd0;
        resp_err_d   = 1'b0;
        state_d      = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      funct3_q     <= 3'd0;
      lane_q       <= 2'd0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      funct3_q     <= funct3_d;
      lane_q       <= lane_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Gating with rst lets a reset landing in WR kill the write in that same cycle.
  assign req_ready  = (state_q == IDLE) && rst;
  assign mem_write  = (state_q == WR) && rst;
  assign resp_valid = (state_q == RESP) && rst;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
endmodule
